// File: rtl/i2c_slave_mem.sv
// I2C slave with a DEPTH-byte register file: pointer-addressed writes, auto-incrementing reads.
// Latency: pin to filtered level 2+FILT clocks, actions one clock later; backpressure: none (SCL never stretched).
module i2c_slave_mem #(
  parameter logic [6:0] SLV_ADDR = 7'h22,
  parameter int         DEPTH    = 16,
  parameter int         FILT     = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     scl_i,
  input  logic                     sda_i,
  output logic                     sda_oe,
  output logic                     busy,
  output logic                     wr_strobe,
  output logic [$clog2(DEPTH)-1:0] wr_addr,
  output logic [7:0]               wr_data
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(FILT + 1);

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, WR_PTR, PTR_ACK, WR_DATA, DATA_ACK, RD_DATA, RD_ACK, WAIT
  } state_t;

  // Line index 1 is SCL, index 0 is SDA.
  logic [1:0]    sync1, sync2, filt, filt_d;
  logic [CW-1:0] cnt [2];

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1  <= 2'b11;
      sync2  <= 2'b11;
      filt   <= 2'b11;
      filt_d <= 2'b11;
      for (int i = 0; i < 2; i++) cnt[i] <= '0;
    end else begin
      sync1  <= {scl_i, sda_i};
      sync2  <= sync1;
      filt_d <= filt;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == filt[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CW'(FILT - 1)) begin
          filt[i] <= sync2[i];
          cnt[i]  <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  logic scl_f, sda_f, scl_rise, scl_fall, start, stop;

  assign scl_f    = filt[1];
  assign sda_f    = filt[0];
  assign scl_rise = filt[1] & ~filt_d[1];
  assign scl_fall = ~filt[1] & filt_d[1];
  // SCL must be high and steady; an SDA move coincident with an SCL move is data.
  assign start    = ~filt[0] & filt_d[0] & scl_f & filt_d[1];
  assign stop     = filt[0] & ~filt_d[0] & scl_f & filt_d[1];

  state_t        state, state_n;
  logic [3:0]    bitcnt, bitcnt_n;
  logic [7:0]    shift, shift_n, rx_byte, rd_byte;
  logic [AW-1:0] ptr, ptr_n;
  logic          oe_n, we;
  logic [7:0]    mem [DEPTH];

  assign rx_byte = {shift[6:0], sda_f};
  assign rd_byte = mem[ptr];
  assign busy    = (state != IDLE);

  always_comb begin
    state_n  = state;
    bitcnt_n = bitcnt;
    shift_n  = shift;
    ptr_n    = ptr;
    oe_n     = sda_oe;
    we       = 1'b0;
    if (start) begin
      state_n  = ADDR;
      bitcnt_n = 4'd0;
      oe_n     = 1'b0;
    end else if (stop) begin
      state_n = IDLE;
      oe_n    = 1'b0;
    end else begin
      case (state)
        ADDR, WR_PTR, WR_DATA: begin
          if (scl_rise && bitcnt != 4'd8) begin
            shift_n  = rx_byte;
            bitcnt_n = bitcnt + 1'b1;
            // The write commits on the last data bit, ahead of the ACK slot.
            if (state == WR_DATA && bitcnt == 4'd7) begin
              we    = 1'b1;
              ptr_n = ptr + 1'b1;
            end
          end else if (scl_fall && bitcnt == 4'd8) begin
            oe_n = 1'b1;
            if (state == ADDR) begin
              if (shift[7:1] == SLV_ADDR) begin
                state_n = ADDR_ACK;
              end else begin
                state_n = IDLE;
                oe_n    = 1'b0;
              end
            end else if (state == WR_PTR) begin
              ptr_n   = shift[AW-1:0];
              state_n = PTR_ACK;
            end else begin
              state_n = DATA_ACK;
            end
          end
        end
        ADDR_ACK: begin
          if (scl_fall) begin
            oe_n     = 1'b0;
            bitcnt_n = 4'd0;
            state_n  = WR_PTR;
            if (shift[0]) begin
              state_n  = RD_DATA;
              shift_n  = rd_byte;
              oe_n     = ~rd_byte[7];
              bitcnt_n = 4'd1;
            end
          end
        end
        PTR_ACK, DATA_ACK: begin
          if (scl_fall) begin
            oe_n     = 1'b0;
            bitcnt_n = 4'd0;
            state_n  = WR_DATA;
          end
        end
        RD_DATA: begin
          if (scl_fall) begin
            if (bitcnt == 4'd8) begin
              oe_n    = 1'b0;
              ptr_n   = ptr + 1'b1;
              state_n = RD_ACK;
            end else begin
              oe_n     = ~shift[6];
              shift_n  = {shift[6:0], 1'b0};
              bitcnt_n = bitcnt + 1'b1;
            end
          end
        end
        RD_ACK: begin
          if (scl_rise && sda_f) begin
            state_n = WAIT;
          end else if (scl_fall) begin
            state_n  = RD_DATA;
            shift_n  = rd_byte;
            oe_n     = ~rd_byte[7];
            bitcnt_n = 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      bitcnt    <= 4'd0;
      shift     <= 8'h00;
      ptr       <= '0;
      sda_oe    <= 1'b0;
      wr_strobe <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= 8'h00;
      for (int i = 0; i < DEPTH; i++) mem[i] <= 8'h00;
    end else begin
      state     <= state_n;
      bitcnt    <= bitcnt_n;
      shift     <= shift_n;
      ptr       <= ptr_n;
      sda_oe    <= oe_n;
      wr_strobe <= we;
      if (we) begin
        wr_addr  <= ptr;
        wr_data  <= rx_byte;
        mem[ptr] <= rx_byte;
      end
    end
  end
endmodule

// File: tb/tb_i2c_slave_mem.sv
// Directed bench for i2c_slave_mem: table of bus transactions plus hand-written glitch and reset sequences.
module tb_i2c_slave_mem;
  localparam int T = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic       sda_line;
  logic       sda_oe, busy, wr_strobe;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;

  int n_cmp = 0;
  int n_bad = 0;

  assign sda_line = sda_m & ~sda_oe;

  i2c_slave_mem #(.SLV_ADDR(7'h22), .DEPTH(16), .FILT(3)) dut (
    .clk(clk), .rst(rst), .scl_i(scl_m), .sda_i(sda_line),
    .sda_oe(sda_oe), .busy(busy), .wr_strobe(wr_strobe),
    .wr_addr(wr_addr), .wr_data(wr_data)
  );

  always #5 clk = ~clk;

  logic [7:0] q_addr[$];
  logic [7:0] q_data[$];
  logic       strb_prev = 1'b0;
  logic       oe_seen = 1'b0;
  int         strb_long = 0;
  int         strb_late = 0;

  always @(negedge clk) begin
    if (!rst && wr_strobe) begin
      q_addr.push_back(8'(wr_addr));
      q_data.push_back(wr_data);
      if (strb_prev) strb_long++;
      if (sda_oe) strb_late++;
    end
    if (sda_oe) oe_seen = 1'b1;
    strb_prev = wr_strobe;
  end

  typedef struct {
    logic       rd;
    logic       set_ptr;
    logic [6:0] dev;
    logic [7:0] ptr;
    logic [7:0] d0, d1;
    logic       exp_ack;
    logic [7:0] e0, e1;
    int         n_strb;
    logic [7:0] a0, a1;
  } vec_t;

  function automatic vec_t mk(logic rd, logic set_ptr, logic [6:0] dev, logic [7:0] ptr,
                              logic [7:0] d0, logic [7:0] d1, logic exp_ack,
                              logic [7:0] e0, logic [7:0] e1, int n_strb,
                              logic [7:0] a0, logic [7:0] a1);
    vec_t v;
    v.rd = rd; v.set_ptr = set_ptr; v.dev = dev; v.ptr = ptr; v.d0 = d0; v.d1 = d1;
    v.exp_ack = exp_ack; v.e0 = e0; v.e1 = e1; v.n_strb = n_strb; v.a0 = a0; v.a1 = a1;
    return v;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; wait_clk(T);
    scl_m = 1'b1; wait_clk(T);
    sda_m = 1'b0; wait_clk(T);
    scl_m = 1'b0; wait_clk(T);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; wait_clk(T);
    scl_m = 1'b1; wait_clk(T);
    sda_m = 1'b1; wait_clk(T);
  endtask

  task automatic write_bit(input logic b);
    sda_m = b;    wait_clk(T);
    scl_m = 1'b1; wait_clk(T);
    scl_m = 1'b0; wait_clk(T);
  endtask

  task automatic write_bit_glitch();
    sda_m = 1'b1; wait_clk(T);
    scl_m = 1'b1; wait_clk(4);
    sda_m = 1'b0; wait_clk(1);
    sda_m = 1'b1; wait_clk(T - 5);
    scl_m = 1'b0; wait_clk(T);
  endtask

  task automatic read_bit(output logic b);
    sda_m = 1'b1; wait_clk(T);
    scl_m = 1'b1; wait_clk(T / 2);
    b = sda_line; wait_clk(T / 2);
    scl_m = 1'b0; wait_clk(T);
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) write_bit(d[i]);
    read_bit(ack);
  endtask

  task automatic read_byte(output logic [7:0] d, input logic ack);
    logic bt;
    for (int i = 7; i >= 0; i--) begin
      read_bit(bt);
      d[i] = bt;
    end
    write_bit(ack);
  endtask

  task automatic do_vec(input vec_t v, input int idx);
    logic       a;
    logic [7:0] b;
    int         q0;
    q0 = q_addr.size();
    oe_seen = 1'b0;
    i2c_start();
    if (!v.rd || v.set_ptr) begin
      write_byte({v.dev, 1'b0}, a);
      check($sformatf("v%0d addr_w_ack", idx), a, v.exp_ack);
      write_byte(v.ptr, a);
      check($sformatf("v%0d ptr_ack", idx), a, v.exp_ack);
    end
    if (v.rd) begin
      if (v.set_ptr) i2c_start();
      write_byte({v.dev, 1'b1}, a);
      check($sformatf("v%0d addr_r_ack", idx), a, v.exp_ack);
      read_byte(b, 1'b0);
      check($sformatf("v%0d rd_byte0", idx), b, v.e0);
      read_byte(b, 1'b1);
      check($sformatf("v%0d rd_byte1", idx), b, v.e1);
      check($sformatf("v%0d oe_after_nack", idx), sda_oe, 1'b0);
    end else begin
      write_byte(v.d0, a);
      check($sformatf("v%0d data0_ack", idx), a, v.exp_ack);
      write_byte(v.d1, a);
      check($sformatf("v%0d data1_ack", idx), a, v.exp_ack);
    end
    check($sformatf("v%0d busy_before_stop", idx), busy, !v.exp_ack);
    i2c_stop();
    wait_clk(10);
    check($sformatf("v%0d busy_after_stop", idx), busy, 1'b0);
    check($sformatf("v%0d oe_after_stop", idx), sda_oe, 1'b0);
    if (v.exp_ack) check($sformatf("v%0d oe_never_driven", idx), oe_seen, 1'b0);
    check($sformatf("v%0d strobe_count", idx), q_addr.size() - q0, v.n_strb);
    for (int k = 0; k < v.n_strb; k++) begin
      if (q0 + k < q_addr.size()) begin
        check($sformatf("v%0d strobe%0d_addr", idx, k), q_addr[q0 + k], (k == 0) ? v.a0 : v.a1);
        check($sformatf("v%0d strobe%0d_data", idx, k), q_data[q0 + k], (k == 0) ? v.e0 : v.e1);
      end
    end
  endtask

  initial begin
    vec_t       vecs[6];
    logic       a;
    int         q0;

    vecs[0] = mk(1'b0, 1'b1, 7'h22, 8'h03, 8'hA5, 8'h5A, 1'b0, 8'hA5, 8'h5A, 2, 8'h03, 8'h04);
    vecs[1] = mk(1'b1, 1'b0, 7'h22, 8'h00, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 0, 8'h00, 8'h00);
    vecs[2] = mk(1'b1, 1'b1, 7'h22, 8'h03, 8'h00, 8'h00, 1'b0, 8'hA5, 8'h5A, 0, 8'h00, 8'h00);
    vecs[3] = mk(1'b0, 1'b1, 7'h23, 8'h03, 8'h11, 8'h22, 1'b1, 8'h00, 8'h00, 0, 8'h00, 8'h00);
    vecs[4] = mk(1'b0, 1'b1, 7'h22, 8'h0F, 8'h11, 8'h22, 1'b0, 8'h11, 8'h22, 2, 8'h0F, 8'h00);
    vecs[5] = mk(1'b1, 1'b1, 7'h22, 8'h0F, 8'h00, 8'h00, 1'b0, 8'h11, 8'h22, 0, 8'h00, 8'h00);

    rst = 1'b1;
    wait_clk(3);
    rst = 1'b0;
    wait_clk(2);
    check("reset sda_oe", sda_oe, 1'b0);
    check("reset busy", busy, 1'b0);
    check("reset wr_strobe", wr_strobe, 1'b0);
    check("reset wr_addr", wr_addr, 4'h0);
    check("reset wr_data", wr_data, 8'h00);

    for (int i = 0; i < 6; i++) do_vec(vecs[i], i);

    // Glitch rejection while idle and mid-byte, then STOP inside a data byte.
    sda_m = 1'b0; wait_clk(1);
    sda_m = 1'b1; wait_clk(20);
    check("idle_glitch busy", busy, 1'b0);
    q0 = q_addr.size();
    i2c_start();
    write_byte(8'h44, a);
    check("glitch addr_ack", a, 1'b0);
    write_byte(8'h07, a);
    check("glitch ptr_ack", a, 1'b0);
    for (int i = 7; i >= 0; i--) begin
      if (i == 2) write_bit_glitch();
      else write_bit(1'b1);
    end
    read_bit(a);
    check("glitch data_ack", a, 1'b0);
    check("glitch busy", busy, 1'b1);
    check("glitch strobe_count", q_addr.size() - q0, 1);
    if (q_addr.size() > q0) begin
      check("glitch strobe_addr", q_addr[q0], 8'h07);
      check("glitch strobe_data", q_data[q0], 8'hFF);
    end
    write_bit(1'b1);
    write_bit(1'b0);
    i2c_stop();
    wait_clk(10);
    check("midbyte_stop busy", busy, 1'b0);
    check("midbyte_stop strobe_count", q_addr.size() - q0, 1);
    do_vec(mk(1'b1, 1'b1, 7'h22, 8'h07, 8'h00, 8'h00, 1'b0, 8'hFF, 8'h00, 0, 8'h00, 8'h00), 6);

    // Reset while the slave is driving bit7=0 of mem[0] (8'h22).
    i2c_start();
    write_byte(8'h44, a);
    write_byte(8'h00, a);
    check("rst_seq ptr_ack", a, 1'b0);
    i2c_start();
    write_byte(8'h45, a);
    check("rst_seq addr_r_ack", a, 1'b0);
    check("rst_seq driving_low", sda_oe, 1'b1);
    rst = 1'b1;
    wait_clk(1);
    check("rst_seq oe_released", sda_oe, 1'b0);
    check("rst_seq busy", busy, 1'b0);
    rst = 1'b0;
    i2c_stop();
    wait_clk(10);
    do_vec(mk(1'b1, 1'b0, 7'h22, 8'h00, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 0, 8'h00, 8'h00), 7);

    check("strobe_single_cycle", strb_long, 0);
    check("strobe_before_ack_drive", strb_late, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
